// File: rtl/csr_pkg.sv
// Shared CSR-side definitions: interrupt cause base value and the
// interrupt sequencing state encoding.
package csr_pkg;

   localparam logic [31:0] IRQ_MCAUSE_BASE = 32'h8000_0010;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRAP    = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational lowest-index-first priority encoder for the interrupt
// candidate vector.
module irq_priority_enc #(
   parameter int IRQ_NUM = 16,
   parameter int IDW     = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1
) (
   input  logic [IRQ_NUM-1:0] vec_i,
   output logic               valid_o,
   output logic [IDW-1:0]     idx_o
);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      // Scan downward so the last assignment is the lowest set bit.
      for (int k = IRQ_NUM - 1; k >= 0; k--) begin
         if (vec_i[k]) begin
            valid_o = 1'b1;
            idx_o   = IDW'(k);
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: masks, prioritises and sequences trap entry/return.
// Define IRQ_EDGE_EN for edge-triggered pending latches; default is level-sensitive.
module irq_controller
   import csr_pkg::*;
#(
   parameter int          IRQ_NUM     = 16,
   parameter logic [31:0] MCAUSE_BASE = IRQ_MCAUSE_BASE
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IRQ_NUM-1:0] irq_req_i,
   input  logic [31:0]        mie_i,
   input  logic               exception_i,
   input  logic               mret_i,
   output logic               irq_o,
   output logic [31:0]        irq_cause_o,
   output logic [IRQ_NUM-1:0] irq_ret_o
);

   localparam int IDW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

   irq_state_t         state_q, state_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [31:0]        cause_q, cause_d;
   logic               irq_q, irq_d;
   logic [IRQ_NUM-1:0] ret_q, ret_d;

   logic [IRQ_NUM-1:0] pending;
   logic [IRQ_NUM-1:0] cand;
   logic               enc_valid;
   logic [IDW-1:0]     enc_idx;
   logic               unused_mie;

   assign unused_mie = ^mie_i[31:IRQ_NUM];

`ifdef IRQ_EDGE_EN
   logic [IRQ_NUM-1:0] pending_q, pending_d;
   logic [IRQ_NUM-1:0] prev_q, prev_d;

   // A new rising edge beats the acknowledge clear on the same line.
   always_comb begin
      prev_d    = irq_req_i;
      pending_d = (pending_q & ~ret_q) | (irq_req_i & ~prev_q);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pending_q <= '0;
         prev_q    <= '0;
      end else begin
         pending_q <= pending_d;
         prev_q    <= prev_d;
      end
   end

   assign pending = pending_q;
`else
   assign pending = irq_req_i;
`endif

   // The source being acknowledged is held off for the acknowledge cycle, giving
   // the device (or the pending clear) one cycle to drop it.
   assign cand = pending & mie_i[IRQ_NUM-1:0] & ~ret_q;

   irq_priority_enc #(
      .IRQ_NUM (IRQ_NUM),
      .IDW     (IDW)
   ) u_enc (
      .vec_i   (cand),
      .valid_o (enc_valid),
      .idx_o   (enc_idx)
   );

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      cause_d = cause_q;
      irq_d   = 1'b0;
      ret_d   = '0;
      case (state_q)
         IDLE: begin
            if (enc_valid && !exception_i) begin
               state_d = TRAP;
               id_d    = enc_idx;
               irq_d   = 1'b1;
               cause_d = MCAUSE_BASE + 32'(enc_idx);
            end
         end
         TRAP: begin
            state_d = SERVICE;
         end
         SERVICE: begin
            if (mret_i) begin
               state_d = IDLE;
               for (int k = 0; k < IRQ_NUM; k++) begin
                  ret_d[k] = (id_q == IDW'(k));
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         id_q    <= '0;
         cause_q <= '0;
         irq_q   <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         cause_q <= cause_d;
         irq_q   <= irq_d;
         ret_q   <= ret_d;
      end
   end

   assign irq_o       = irq_q;
   assign irq_cause_o = cause_q;
   assign irq_ret_o   = ret_q;

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that sequences trap entry for the CSR controller. Collects up to `IRQ_NUM` peripheral interrupt requests, masks them with the `mie` CSR, and picks the highest-priority one. It raises a one-cycle trap request with the matching `mcause` value, then holds off further interrupts until `mret`. On `mret` it acknowledges the serviced source. Its `irq_o`/`irq_cause_o` outputs feed the CSR controller's `trap_i`/`mcause_i` inputs.

## Interface
Parameters:
- `IRQ_NUM`, default 16: number of interrupt sources, 1..31.
- `MCAUSE_BASE`, default 32'h8000_0010: `mcause` value of source 0. Source k reports `MCAUSE_BASE + k`.

Ports:
- `clk_i`  in  1  clock. One clock domain only.
- `rst_i`  in  1  reset, synchronous, active-low.
- `irq_req_i`  in  IRQ_NUM  interrupt request lines from peripherals.
- `mie_i`  in  32  `mie` CSR value. Bit k enables source k; bits ≥ IRQ_NUM are ignored.
- `exception_i`  in  1  a synchronous exception is being taken this cycle.
- `mret_i`  in  1  `mret` instruction retiring this cycle.
- `irq_o`  out  1  trap request, one-cycle pulse.
- `irq_cause_o`  out  32  `mcause` value for the current interrupt.
- `irq_ret_o`  out  IRQ_NUM  one-hot acknowledge to the serviced source, one-cycle pulse.

## Operation
- Reset (`rst_i`=0 at a clock edge) puts the block in this state:
  - FSM = IDLE.
  - pending = 0, id = 0.
  - `irq_o` = 0, `irq_cause_o` = 0, `irq_ret_o` = 0.
- Candidate vector: `pending & mie_i[IRQ_NUM-1:0]` (see Configuration for how pending is formed).
- Priority: lowest set index wins.
- FSM states:
  - IDLE
    - Candidate ≠ 0 and `exception_i`=0: latch the winning index into id, go to TRAP.
    - `exception_i`=1: stay in IDLE; the interrupt is deferred, not lost.
  - TRAP (1 cycle)
    - `irq_o`=1 and `irq_cause_o = MCAUSE_BASE + id`.
    - Unconditionally go to SERVICE.
  - SERVICE
    - `irq_cause_o` holds its value.
    - Wait for `mret_i`=1, then pulse `irq_ret_o[id]`=1 for the next cycle and go to IDLE.
- `mret_i` in IDLE or TRAP is ignored.
- `exception_i` in TRAP or SERVICE is ignored; nesting is not supported.
- `mie_i` changes after the winner is latched do not affect the interrupt in service.
- Arithmetic for `irq_cause_o`: 32-bit add, wraps modulo 2^32.

## Timing
- Latency to trap: a qualifying candidate seen in IDLE at edge N gives `irq_o`=1 in cycle N+1. `irq_o` is registered and never combinational from inputs.
- `irq_o` is high for exactly 1 cycle per interrupt.
- Acknowledge: `mret_i` seen in SERVICE at edge M gives `irq_ret_o[id]`=1 in cycle M+1, with the FSM back in IDLE.
- A new trap can start no earlier than M+2. There is at least one IDLE cycle between interrupts.
- Simultaneous events:
  - In the edge-triggered build, the pending clear from an acknowledge and a new rising edge on the same line can coincide. The set wins: pending stays 1.
  - If several candidates rise in the same cycle, only the lowest index is taken. The others remain candidates.
- Reset mid-operation (TRAP or SERVICE): FSM returns to IDLE. No `irq_ret_o` pulse is produced, and pending is cleared.

## Configuration
- Macro: `IRQ_EDGE_EN`.
- Defined (edge-triggered):
  - pending[k] is set on a 0→1 transition of `irq_req_i[k]`, using a registered previous-value vector.
  - pending[k] is cleared in the cycle `irq_ret_o[k]` pulses.
  - A pulse shorter than the service time is remembered.
- Undefined (level-sensitive):
  - There is no pending register; pending = `irq_req_i` directly.
  - A device must hold its request until it sees `irq_ret_o`.
  - A request dropped before IDLE samples it is lost.

## Structure
- `csr_pkg` gets `IRQ_MCAUSE_BASE` (default for `MCAUSE_BASE`) and the `irq_state_t` enum {IDLE, TRAP, SERVICE}.
- Sub-module `irq_priority_enc`, parameterised by `IRQ_NUM`:
  - input: a vector of `IRQ_NUM` bits;
  - outputs: `valid` and `$clog2(IRQ_NUM)`-bit `idx` of the lowest set bit;
  - purely combinational.

## Test plan
- Basic trap:
  - Stimulus: `mie_i`=32'h0000_0008, `irq_req_i`[3] raised.
  - Response: one cycle later `irq_o`=1 for 1 cycle with `irq_cause_o`=32'h8000_0013. `mret_i` pulse → next cycle `irq_ret_o`=16'h0008.
- Priority and deferral:
  - Stimulus: `irq_req_i`[5] and [2] raised in the same cycle, `mie_i`=32'hFFFF.
  - Response: cause 32'h8000_0012 first. After `mret_i`, source 5 traps with 32'h8000_0015, no earlier than 2 cycles after `mret_i`.
- Masking and exception:
  - With `mie_i`=0, `irq_req_i`[0] high gives no `irq_o`.
  - Setting `mie_i`=1 while `exception_i`=1 for 3 cycles still gives no `irq_o`.
  - `irq_o` appears one cycle after `exception_i` falls.
- Stray and nested events:
  - `mret_i` pulsed in IDLE produces no `irq_ret_o`.
  - `irq_req_i`[1] rising during SERVICE of source 0 produces no `irq_o` until after `mret_i`.
- Reset mid-service:
  - Stimulus: `rst_i`=0 for 1 cycle while in SERVICE.
  - Response: all outputs 0. A later `mret_i` gives no `irq_ret_o`.
- `IRQ_EDGE_EN` build:
  - A 1-cycle pulse on `irq_req_i`[4] during SERVICE of source 0 is traps later with cause 32'h8000_0014.
  - Without the macro, the same pulse is never taken.
